// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: state encoding and default frame constants.
package uart_tx_pkg;

   // 2-bit state encoding; the values are fixed so debug taps and matching receivers agree
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   localparam int DEF_DBIT    = 8;
   localparam int DEF_SB_TICK = 16;
   localparam int DEF_OVS     = 16;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter width able to index 0..n-1; never zero so degenerate parameters still elaborate
   function automatic int width_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, stop bit, paced by an external
// oversample strobe. Line output is registered so it never glitches.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int DBIT    = DEF_DBIT,
   parameter int SB_TICK = DEF_SB_TICK,
   parameter int OVS     = DEF_OVS
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] din,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int CNT_W = width_for(max_i(OVS, SB_TICK));
   localparam int IDX_W = width_for(DBIT);

   localparam logic [CNT_W-1:0] OVS_LAST = CNT_W'(OVS - 1);
   localparam logic [CNT_W-1:0] SB_LAST  = CNT_W'(SB_TICK - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DBIT - 1);

   state_e            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg,   cnt_next;
   logic [IDX_W-1:0]  idx_reg,   idx_next;
   logic [DBIT-1:0]   sh_reg,    sh_next;
   logic              tx_reg,    tx_next;
   logic              done_reg,  done_next;

   // State and datapath registers; reset parks the line high and drops any frame in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         sh_reg    <= '0;
         tx_reg    <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         sh_reg    <= sh_next;
         tx_reg    <= tx_next;
         done_reg  <= done_next;
      end
   end

   // Next-state logic; counters only move on s_tick, and each bit ends on its last tick
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      sh_next    = sh_reg;
      tx_next    = tx_reg;
      done_next  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            tx_next = 1'b1;
            if (tx_start) begin
               sh_next    = din;
               cnt_next   = '0;
               state_next = S_START;
            end
         end
         S_START: begin
            tx_next = 1'b0;
            if (s_tick) begin
               if (cnt_reg == OVS_LAST) begin
                  cnt_next   = '0;
                  idx_next   = '0;
                  state_next = S_DATA;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         S_DATA: begin
            tx_next = sh_reg[0];
            if (s_tick) begin
               if (cnt_reg == OVS_LAST) begin
                  cnt_next = '0;
                  sh_next  = sh_reg >> 1;
                  if (idx_reg == IDX_LAST) begin
                     state_next = S_STOP;
                  end else begin
                     idx_next = idx_reg + IDX_W'(1);
                  end
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         S_STOP: begin
            tx_next = 1'b1;
            if (s_tick) begin
               if (cnt_reg == SB_LAST) begin
                  cnt_next   = '0;
                  done_next  = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         default: begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   assign tx           = tx_reg;
   assign tx_done_tick = done_reg;
   assign tx_busy      = (state_reg != S_IDLE);

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DBIT, default 8: number of data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16: s_tick count spanning the stop bit.
REQ-003 SHALL have parameter OVS, default 16: s_tick count per start bit and per data bit.
REQ-004 SHALL have port clk, input, 1: single system clock, rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port s_tick, input, 1: one-clk-wide oversample strobe from an external tick generator.
REQ-007 SHALL have port tx_start, input, 1: request to send din; single-cycle or held.
REQ-008 SHALL have port din, input, DBIT: data word to send.
REQ-009 SHALL have port tx, output, 1: serial line, registered, idle-high.
REQ-010 SHALL have port tx_busy, output, 1: high in every state except idle.
REQ-011 SHALL have port tx_done_tick, output, 1: one-clk pulse at end of stop bit.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; all state changes on clk rising edge.
REQ-013 IDLE: tx=1; on tx_start=1, SHALL latch din into shift register, clear tick counter, go to START next cycle, independent of s_tick.
REQ-014 START: tx=0; SHALL count s_tick; on the s_tick that completes OVS counts, clear counter and bit index, go to DATA.
REQ-015 DATA: tx = shift_reg[0] (LSB first); on the s_tick completing OVS counts, shift right by one and increment bit index; after bit DBIT-1, go to STOP.
REQ-016 STOP: tx=1; on the s_tick completing SB_TICK counts, go to IDLE and assert tx_done_tick for exactly that one cycle.
REQ-017 Tick counter SHALL advance only on cycles with s_tick=1; cycles without s_tick leave all counters unchanged.
REQ-018 tx_start SHALL be ignored outside IDLE; din changes after acceptance SHALL NOT affect the frame in flight.
REQ-019 After tx_done_tick, FSM SHALL spend at least one cycle in IDLE; a tx_start held high through done starts the next frame on the following cycle.
REQ-020 Tick counter width SHALL be clog2(max(OVS,SB_TICK)); bit index width SHALL be clog2(DBIT); counters SHALL never wrap mid-bit.
REQ-021 tx SHALL be driven from a flop (no combinational glitching); its value changes one clk after the state/bit transition that selects it.
REQ-022 Frame length SHALL be exactly OVS*(1+DBIT)+SB_TICK s_tick pulses from START entry to tx_done_tick.

Reset
REQ-023 reset=0 SHALL immediately force state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, counters=0, shift register=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no tx_done_tick; the line returns high asynchronously.
REQ-025 First tx_start SHALL be honoured on the first clk edge after reset deasserts.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3) and default DBIT/OVS/SB_TICK constants.
REQ-027 Block SHALL be one module with no sub-modules; the tick source stays external so the same tick generator can feed a matching receiver.

Verification
REQ-028 Reset: hold reset=0 for 3 clk, toggle tx_start -> tx=1, tx_busy=0, no tx_done_tick.
REQ-029 Basic frame: s_tick every 4 clk, din=8'hA5, pulse tx_start -> tx=0 for 16 ticks, then 1,0,1,0,0,1,0,1 for 16 ticks each, then 1 for 16 ticks; tx_done_tick once after 160 ticks.
REQ-030 Busy rejection: pulse tx_start with din=8'h3C during the DATA state of a frame carrying 8'hA5 -> line carries only 8'hA5; one tx_done_tick.
REQ-031 Back-to-back: hold tx_start=1, din=8'h00 then 8'hFF -> two frames separated by at least 1 idle clk; two tx_done_ticks.
REQ-032 Reset mid-frame: assert reset during data bit 3 -> tx=1 within same cycle, tx_busy=0, no tx_done_tick; next tx_start sends a clean frame.
REQ-033 Tick gating: hold s_tick=0 for 100 clk during START -> tx stays 0 and counter frozen; resume -> START lasts exactly 16 ticks in total.
